// File: rtl/control_unit_if.sv
// Control bundle between the sequencer and the 8-bit accumulator datapath.
// master = control_unit (drives loads/selects/write), slave = datapath (drives IR and stored flags).
interface control_unit_if;
  logic [7:0] IR;
  logic [3:0] CCR_Result;
  logic       IR_Load;
  logic       MAR_Load;
  logic       PC_Load;
  logic       PC_Inc;
  logic       A_Load;
  logic       B_Load;
  logic [2:0] ALU_Sel;
  logic       CCR_Load;
  logic [1:0] Bus1_Sel;
  logic [1:0] Bus2_Sel;
  logic       write;

  modport master (
    input  IR, CCR_Result,
    output IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load,
           ALU_Sel, CCR_Load, Bus1_Sel, Bus2_Sel, write
  );

  modport slave (
    output IR, CCR_Result,
    input  IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load,
           ALU_Sel, CCR_Load, Bus1_Sel, Bus2_Sel, write
  );
endinterface

// File: rtl/control_unit.sv
// Moore FSM sequencing fetch/decode/execute for the accumulator datapath; outputs decode from state only.
// One state per clock, no backpressure: instructions take 4 (NOP) to 9 (direct load) cycles.
module control_unit (
  input  logic           Clk,
  input  logic           Reset,
  control_unit_if.master cu
);

  localparam logic [4:0] S_FETCH_0   = 5'd0,  S_FETCH_1   = 5'd1,  S_FETCH_2   = 5'd2,
                         S_DECODE_3  = 5'd3,  S_OPR_4     = 5'd4,  S_OPR_5     = 5'd5,
                         S_LDA_IMM_6 = 5'd6,  S_LDB_IMM_6 = 5'd7,  S_DIR_6     = 5'd8,
                         S_DIR_7     = 5'd9,  S_STA_7     = 5'd10, S_STB_7     = 5'd11,
                         S_LDA_DIR_8 = 5'd12, S_LDB_DIR_8 = 5'd13, S_BR_4      = 5'd14,
                         S_BR_5      = 5'd15, S_BR_6      = 5'd16, S_SKIP_4    = 5'd17,
                         S_ADD_4     = 5'd18, S_SUB_4     = 5'd19, S_AND_4     = 5'd20,
                         S_OR_4      = 5'd21;

  localparam logic [7:0] OP_LDA_IMM = 8'h86, OP_LDA_DIR = 8'h87, OP_LDB_IMM = 8'h88,
                         OP_LDB_DIR = 8'h89, OP_STA_DIR = 8'h96, OP_STB_DIR = 8'h97,
                         OP_ADD_AB  = 8'h42, OP_SUB_AB  = 8'h43, OP_AND_AB  = 8'h44,
                         OP_OR_AB   = 8'h45, OP_BRA     = 8'h20, OP_BEQ     = 8'h23,
                         OP_BNE     = 8'h24;

  logic [4:0] state_q, state_d;
  logic       z_flag;

  assign z_flag = cu.CCR_Result[2];

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= S_FETCH_0;
    else       state_q <= state_d;
  end

  // Operand-phase states are shared across loads/stores; IR is stable until the next fetch, so it steers the split.
  always_comb begin
    state_d = S_FETCH_0;
    case (state_q)
      S_FETCH_0: state_d = S_FETCH_1;
      S_FETCH_1: state_d = S_FETCH_2;
      S_FETCH_2: state_d = S_DECODE_3;
      S_DECODE_3: begin
        case (cu.IR)
          OP_LDA_IMM, OP_LDB_IMM, OP_LDA_DIR,
          OP_LDB_DIR, OP_STA_DIR, OP_STB_DIR: state_d = S_OPR_4;
          OP_ADD_AB: state_d = S_ADD_4;
          OP_SUB_AB: state_d = S_SUB_4;
          OP_AND_AB: state_d = S_AND_4;
          OP_OR_AB:  state_d = S_OR_4;
          OP_BRA:    state_d = S_BR_4;
          OP_BEQ:    state_d = z_flag ? S_BR_4 : S_SKIP_4;
          OP_BNE:    state_d = z_flag ? S_SKIP_4 : S_BR_4;
          default:   state_d = S_FETCH_0;
        endcase
      end
      S_OPR_4: state_d = S_OPR_5;
      S_OPR_5: begin
        case (cu.IR)
          OP_LDA_IMM: state_d = S_LDA_IMM_6;
          OP_LDB_IMM: state_d = S_LDB_IMM_6;
          OP_LDA_DIR, OP_LDB_DIR, OP_STA_DIR, OP_STB_DIR: state_d = S_DIR_6;
          default:    state_d = S_FETCH_0;
        endcase
      end
      S_DIR_6: begin
        case (cu.IR)
          OP_STA_DIR:             state_d = S_STA_7;
          OP_STB_DIR:             state_d = S_STB_7;
          OP_LDA_DIR, OP_LDB_DIR: state_d = S_DIR_7;
          default:                state_d = S_FETCH_0;
        endcase
      end
      S_DIR_7: state_d = (cu.IR == OP_LDB_DIR) ? S_LDB_DIR_8 : S_LDA_DIR_8;
      S_BR_4:  state_d = S_BR_5;
      S_BR_5:  state_d = S_BR_6;
      default: state_d = S_FETCH_0;
    endcase
  end

  always_comb begin
    cu.IR_Load  = 1'b0;
    cu.MAR_Load = 1'b0;
    cu.PC_Load  = 1'b0;
    cu.PC_Inc   = 1'b0;
    cu.A_Load   = 1'b0;
    cu.B_Load   = 1'b0;
    cu.ALU_Sel  = 3'b000;
    cu.CCR_Load = 1'b0;
    cu.Bus1_Sel = 2'b00;
    cu.Bus2_Sel = 2'b00;
    cu.write    = 1'b0;
    case (state_q)
      S_FETCH_0, S_OPR_4, S_BR_4: begin
        cu.Bus2_Sel = 2'b01;
        cu.MAR_Load = 1'b1;
      end
      S_FETCH_1, S_OPR_5, S_SKIP_4: cu.PC_Inc = 1'b1;
      S_FETCH_2: begin
        cu.Bus2_Sel = 2'b10;
        cu.IR_Load  = 1'b1;
      end
      S_LDA_IMM_6, S_LDA_DIR_8: begin
        cu.Bus2_Sel = 2'b10;
        cu.A_Load   = 1'b1;
      end
      S_LDB_IMM_6, S_LDB_DIR_8: begin
        cu.Bus2_Sel = 2'b10;
        cu.B_Load   = 1'b1;
      end
      S_DIR_6: begin
        cu.Bus2_Sel = 2'b10;
        cu.MAR_Load = 1'b1;
      end
      S_STA_7: begin
        cu.Bus1_Sel = 2'b01;
        cu.write    = 1'b1;
      end
      S_STB_7: begin
        cu.Bus1_Sel = 2'b10;
        cu.write    = 1'b1;
      end
      S_BR_6: begin
        cu.Bus2_Sel = 2'b10;
        cu.PC_Load  = 1'b1;
      end
      S_ADD_4, S_SUB_4, S_AND_4, S_OR_4: begin
        cu.ALU_Sel  = (state_q == S_ADD_4) ? 3'b000 :
                      (state_q == S_SUB_4) ? 3'b001 :
                      (state_q == S_AND_4) ? 3'b010 : 3'b011;
        cu.A_Load   = 1'b1;
        cu.CCR_Load = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: per-instruction summary table, reset-abort sequence, and random instruction stream vs a cycle-trace model.
module tb_control_unit;

  logic clk = 1'b0;
  logic rst;

  control_unit_if bus();

  control_unit dut (
    .Clk   (clk),
    .Reset (rst),
    .cu    (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Observed control word: {IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, ALU_Sel, CCR_Load, Bus1_Sel, Bus2_Sel, write}
  typedef logic [14:0] cw_t;
  cw_t obs;
  assign obs = {bus.IR_Load, bus.MAR_Load, bus.PC_Load, bus.PC_Inc, bus.A_Load, bus.B_Load,
                bus.ALU_Sel, bus.CCR_Load, bus.Bus1_Sel, bus.Bus2_Sel, bus.write};

  function automatic cw_t mk(input logic irl, input logic marl, input logic pcl, input logic pci,
                             input logic al, input logic bl, input logic [2:0] alu, input logic ccrl,
                             input logic [1:0] b1, input logic [1:0] b2, input logic wr);
    return {irl, marl, pcl, pci, al, bl, alu, ccrl, b1, b2, wr};
  endfunction

  function automatic cw_t w_marpc();  return mk(0,1,0,0,0,0,3'd0,0,2'b00,2'b01,0); endfunction
  function automatic cw_t w_pcinc();  return mk(0,0,0,1,0,0,3'd0,0,2'b00,2'b00,0); endfunction
  function automatic cw_t w_memmar(); return mk(0,1,0,0,0,0,3'd0,0,2'b00,2'b10,0); endfunction

  // Expected per-cycle control trace for one instruction, straight from the instruction timing tables.
  cw_t exp_q[$];
  function automatic void build(input logic [7:0] op, input logic [3:0] ccr);
    logic taken;
    logic is_a;
    exp_q.delete();
    exp_q.push_back(w_marpc());
    exp_q.push_back(w_pcinc());
    exp_q.push_back(mk(1,0,0,0,0,0,3'd0,0,2'b00,2'b10,0));
    exp_q.push_back('0);
    taken = (op == 8'h20) || (op == 8'h23 && ccr[2]) || (op == 8'h24 && !ccr[2]);
    is_a  = (op == 8'h86) || (op == 8'h87) || (op == 8'h96);
    case (op)
      8'h86, 8'h88: begin
        exp_q.push_back(w_marpc());
        exp_q.push_back(w_pcinc());
        exp_q.push_back(mk(0,0,0,0,is_a,!is_a,3'd0,0,2'b00,2'b10,0));
      end
      8'h87, 8'h89: begin
        exp_q.push_back(w_marpc());
        exp_q.push_back(w_pcinc());
        exp_q.push_back(w_memmar());
        exp_q.push_back('0);
        exp_q.push_back(mk(0,0,0,0,is_a,!is_a,3'd0,0,2'b00,2'b10,0));
      end
      8'h96, 8'h97: begin
        exp_q.push_back(w_marpc());
        exp_q.push_back(w_pcinc());
        exp_q.push_back(w_memmar());
        exp_q.push_back(mk(0,0,0,0,0,0,3'd0,0,is_a ? 2'b01 : 2'b10,2'b00,1));
      end
      8'h42, 8'h43, 8'h44, 8'h45:
        exp_q.push_back(mk(0,0,0,0,1,0,3'(op - 8'h42),1,2'b00,2'b00,0));
      8'h20, 8'h23, 8'h24: begin
        if (taken) begin
          exp_q.push_back(w_marpc());
          exp_q.push_back('0);
          exp_q.push_back(mk(0,0,1,0,0,0,3'd0,0,2'b00,2'b10,0));
        end else begin
          exp_q.push_back(w_pcinc());
        end
      end
      default: ;
    endcase
  endfunction

  // Entered and left on a falling edge with the DUT in its first fetch state.
  task automatic run_instr(input logic [7:0] op, input logic [3:0] ccr, input string tag);
    build(op, ccr);
    bus.IR         = op;
    bus.CCR_Result = ccr;
    foreach (exp_q[i]) begin
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL %s op=%h ccr=%b cycle=%0d got=%h want=%h", tag, op, ccr, i, obs, exp_q[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  typedef struct {
    logic [7:0] op;
    logic [3:0] ccr;
    int         len;
    int         n_pcinc;
    int         n_pcload;
    int         n_write;
    int         n_aload;
  } vec_t;

  vec_t vecs[12];

  // Instruction length = distance between consecutive IR_Load cycles; counts taken over that span.
  task automatic measure(input vec_t v, input int idx);
    cw_t hist[48];
    int  n_irl = 0;
    int  first = -1;
    int  len   = -1;
    int  pci = 0, pcl = 0, wr = 0, al = 0;
    bus.IR         = v.op;
    bus.CCR_Result = v.ccr;
    for (int c = 0; c < 48 && len < 0; c++) begin
      hist[c] = obs;
      if (obs[14]) begin
        n_irl++;
        if (n_irl == 1) first = c;
        else if (n_irl == 2) len = c - first;
      end
      @(negedge clk);
    end
    if (len < 0) begin
      errors++;
      checks++;
      $display("FAIL vec%0d_timeout op=%h got=no_second_fetch want=len_%0d", idx, v.op, v.len);
    end else begin
      for (int c = 0; c < len; c++) begin
        pci += int'(hist[c][11]);
        pcl += int'(hist[c][12]);
        wr  += int'(hist[c][0]);
        al  += int'(hist[c][10]);
      end
      check($sformatf("vec%0d_len_op%h", idx, v.op), len, v.len);
      check($sformatf("vec%0d_pcinc_op%h", idx, v.op), pci, v.n_pcinc);
      check($sformatf("vec%0d_pcload_op%h", idx, v.op), pcl, v.n_pcload);
      check($sformatf("vec%0d_write_op%h", idx, v.op), wr, v.n_write);
      check($sformatf("vec%0d_aload_op%h", idx, v.op), al, v.n_aload);
    end
  endtask

  logic [7:0] ops[13];

  initial begin
    vecs[0]  = '{8'h86, 4'h0, 7, 2, 0, 0, 1};
    vecs[1]  = '{8'h87, 4'h0, 9, 2, 0, 0, 1};
    vecs[2]  = '{8'h96, 4'h0, 8, 2, 0, 1, 0};
    vecs[3]  = '{8'h97, 4'hF, 8, 2, 0, 1, 0};
    vecs[4]  = '{8'h42, 4'h0, 5, 1, 0, 0, 1};
    vecs[5]  = '{8'h20, 4'h0, 7, 1, 1, 0, 0};
    vecs[6]  = '{8'h23, 4'h4, 7, 1, 1, 0, 0};
    vecs[7]  = '{8'h23, 4'hB, 5, 2, 0, 0, 0};
    vecs[8]  = '{8'h24, 4'h0, 7, 1, 1, 0, 0};
    vecs[9]  = '{8'h24, 4'h4, 5, 2, 0, 0, 0};
    vecs[10] = '{8'hFF, 4'h0, 4, 1, 0, 0, 0};
    vecs[11] = '{8'h88, 4'h0, 7, 2, 0, 0, 0};
    ops = '{8'h86, 8'h87, 8'h88, 8'h89, 8'h96, 8'h97, 8'h42,
            8'h43, 8'h44, 8'h45, 8'h20, 8'h23, 8'h24};

    rst            = 1'b1;
    bus.IR         = 8'h00;
    bus.CCR_Result = 4'h0;
    @(negedge clk);

    do_reset();
    run_instr(8'h86, 4'h0, "lda_imm_after_reset");
    run_instr(8'h87, 4'h0, "lda_dir");
    run_instr(8'h96, 4'h0, "sta_dir");
    run_instr(8'h42, 4'h0, "add_ab");
    run_instr(8'h23, 4'h4, "beq_taken");
    run_instr(8'h23, 4'h0, "beq_not_taken");
    run_instr(8'hFF, 4'h0, "nop_ff");

    foreach (vecs[i]) begin
      do_reset();
      measure(vecs[i], i);
    end

    // Reset during the E6 cycle of STA_DIR: the store must be abandoned.
    do_reset();
    bus.IR         = 8'h96;
    bus.CCR_Result = 4'h0;
    repeat (6) @(negedge clk);
    check("sta_e6_word", int'(obs), int'(w_memmar()));
    rst = 1'b1;
    @(negedge clk);
    check("abort_in_reset_word", int'(obs), int'(w_marpc()));
    @(negedge clk);
    check("abort_held_reset_word", int'(obs), int'(w_marpc()));
    rst    = 1'b0;
    bus.IR = 8'hFF;
    begin
      int wr_seen = 0;
      int marpc   = int'(obs == w_marpc());
      check("abort_release_fetch0", marpc, 1);
      for (int c = 0; c < 8; c++) begin
        wr_seen += int'(bus.write);
        @(negedge clk);
      end
      check("abort_no_write", wr_seen, 0);
    end

    do_reset();
    for (int n = 0; n < 300; n++) begin
      int         k;
      logic [7:0] op;
      k  = $urandom_range(0, 13);
      op = (k == 13) ? 8'($urandom) : ops[k];
      run_instr(op, 4'($urandom), "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
